// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  localparam int unsigned ITER_CNT = 32;
  localparam int unsigned CNT_W    = $clog2(ITER_CNT) + 1;

endpackage

// File: rtl/muldiv_sign.sv
// Sign conditioning for muldiv_unit: operand magnitudes and result sign flags
// on the way in, conditional negation of the raw magnitude result on the way out.
module muldiv_sign
  import muldiv_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] mag_a,
  output logic [31:0] mag_b,
  output logic        neg_res,
  output logic        neg_rem,
  input  logic        is_div,
  input  logic        res_neg,
  input  logic        rem_neg,
  input  logic [63:0] raw,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        signed_op;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    mag_a     = (signed_op && a[31]) ? -a : a;
    mag_b     = (signed_op && b[31]) ? -b : b;
    neg_res   = signed_op && (a[31] ^ b[31]);
    neg_rem   = signed_op && a[31];

    // raw holds {product} for multiply and {remainder, quotient} for divide
    prod   = res_neg ? -raw : raw;
    quo    = res_neg ? -raw[31:0] : raw[31:0];
    rem    = rem_neg ? -raw[63:32] : raw[63:32];
    res_hi = is_div ? rem : prod[63:32];
    res_lo = is_div ? quo : prod[31:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// The restoring divider is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        acc_q, acc_d;
  logic [31:0]        opnd_q, opnd_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [31:0]        mag_a, mag_b;
  logic               neg_res, neg_rem;
  logic [31:0]        fin_hi, fin_lo;
  logic [32:0]        mul_sum;
  logic [63:0]        mul_next;

`ifdef MULDIV_DIV_EN
  logic [31:0]        a_q, a_d;
  logic               bz_q, bz_d;
  logic [32:0]        div_shift;
  logic [32:0]        div_diff;
  logic [63:0]        div_next;
`endif

  muldiv_sign u_sign (
    .op      (op),
    .a       (a),
    .b       (b),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .neg_res (neg_res),
    .neg_rem (neg_rem),
    .is_div  (state_q == DIV),
    .res_neg (neg_res_q),
    .rem_neg (neg_rem_q),
    .raw     (acc_q),
    .res_hi  (fin_hi),
    .res_lo  (fin_lo)
  );

  // acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
    a_d       = a_q;
    bz_d      = bz_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = '0;
          acc_d     = {32'd0, mag_a};
          opnd_d    = mag_b;
          neg_res_d = neg_res;
          neg_rem_d = neg_rem;
          if (!op[1]) begin
            state_d = MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            a_d     = a;
            bz_d    = (b == '0);
            state_d = DIV;
`else
            state_d = DONE;
`endif
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      // One extra cycle after the last iteration applies signs and commits hi/lo
      MUL: begin
        if (cnt_q == CNT_W'(ITER_CNT)) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          state_d = DONE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + 1'b1;
        end
      end

      DIV: begin
`ifdef MULDIV_DIV_EN
        if (cnt_q == CNT_W'(ITER_CNT)) begin
          hi_d    = bz_q ? a_q : fin_hi;
          lo_d    = bz_q ? '1  : fin_lo;
          state_d = DONE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      a_q       <= '0;
      bz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
      a_q       <= a_d;
      bz_q      <= bz_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign div_by_zero = (state_q == DONE) && bz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model (honours MULDIV_DIV_EN).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dbz = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands
  task automatic model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = {{32{xa[31]}}, xa};
    sb = {{32{xb[31]}}, xb};
    ua = {32'd0, xa};
    ub = {32'd0, xb};
    m_dbz = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b01: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      default: begin
        if (DIV_EN) begin
          if (xb == 32'd0) begin
            m_lo  = 32'hFFFF_FFFF;
            m_hi  = xa;
            m_dbz = 1'b1;
          end else if (o == 2'b10) begin
            sq = sa / sb;
            sr = sa % sb;
            m_lo = sq[31:0];
            m_hi = sr[31:0];
          end else begin
            p = ua / ub; m_lo = p[31:0];
            p = ua % ub; m_hi = p[31:0];
          end
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input bit disturb, input bit we_same);
    logic [31:0] pre_hi, pre_lo;
    int dur;
    pre_hi = m_hi;
    pre_lo = m_lo;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    if (we_same) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_0F0F; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    model(o, xa, xb);
    dur = (o[1] && !DIV_EN) ? 0 : 33;
    for (int k = 0; k <= dur; k++) begin
      if (k > 0) @(negedge clk);
      check("done_timing", 64'(done), 64'(k == dur));
      check("busy_active", 64'(busy), 64'd1);
      if (k < dur) begin
        check("hi_hold", 64'(hi), 64'(pre_hi));
        check("lo_hold", 64'(lo), 64'(pre_lo));
      end
      if (disturb && k == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (disturb && k == 6) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
    end
    check("hi_result", 64'(hi), 64'(m_hi));
    check("lo_result", 64'(lo), 64'(m_lo));
    check("dbz_with_done", 64'(div_by_zero), 64'(m_dbz));
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    check("done_after", 64'(done), 64'd0);
    check("dbz_after", 64'(div_by_zero), 64'd0);
    check("hi_after", 64'(hi), 64'(m_hi));
    check("lo_after", 64'(lo), 64'(m_lo));
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d);
    @(negedge clk);
    hi_we = wh; lo_we = wl; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0; wdata = $urandom;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    check("mt_hi", 64'(hi), 64'(m_hi));
    check("mt_lo", 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check("multu_hi_const", 64'(hi), 64'h0000_0001);
    check("multu_lo_const", 64'(lo), 64'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFA, 32'd11, 1'b1, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'd11, 32'd6, 1'b0, 1'b0);
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    mt_write(1'b0, 1'b1, 32'hA5A5_A5A5);
    mt_write(1'b1, 1'b0, 32'h1357_9BDF);
    run_op(2'b01, 32'd2, 32'd3, 1'b1, 1'b1);

    // Reset in the middle of a MULT: everything clears, no done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'hFEDC_BA98;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      else
        run_op(2'($urandom_range(0, 3)), pick(), pick(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL expose: clk  in  1  rising-edge clock.
REQ-003 SHALL expose: rst_n  in  1  async active-low reset.
REQ-004 SHALL expose: start  in  1  request strobe, sampled only in IDLE.
REQ-005 SHALL expose: op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL expose: a  in  32  multiplicand/dividend.
REQ-007 SHALL expose: b  in  32  multiplier/divisor.
REQ-008 SHALL expose: hi_we  in  1  mthi write strobe.
REQ-009 SHALL expose: lo_we  in  1  mtlo write strobe.
REQ-010 SHALL expose: wdata  in  32  mthi/mtlo data.
REQ-011 SHALL expose: busy  out  1  operation in progress.
REQ-012 SHALL expose: done  out  1  one-cycle completion pulse.
REQ-013 SHALL expose: hi  out  32  HI register.
REQ-014 SHALL expose: lo  out  32  LO register.
REQ-015 SHALL expose: div_by_zero  out  1  pulses with done when a divide had b==0.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-017 SHALL transition IDLE->MUL (op[1]==0) or IDLE->DIV (op[1]==1) on start; SHALL latch a, b, op at that edge.
REQ-018 SHALL iterate exactly 32 cycles in MUL/DIV (1 bit per cycle: shift-add multiply, restoring divide), then enter DONE.
REQ-019 SHALL assert done for exactly one cycle in DONE, 33 cycles after the start-sampling edge, then return to IDLE.
REQ-020 SHALL update hi/lo at the edge entering DONE, so hi/lo are valid while done is high.
REQ-021 SHALL assert busy in MUL, DIV, DONE; busy low only in IDLE.
REQ-022 SHALL ignore start when not IDLE; no queuing.
REQ-023 SHALL produce the 64-bit product as {hi,lo}; MULT signed, MULTU unsigned.
REQ-024 SHALL operate on magnitudes for signed ops and apply sign at completion: product sign a^b; quotient sign a^b; remainder sign of a.
REQ-025 SHALL place quotient in lo and remainder in hi for DIV/DIVU.
REQ-026 SHALL, for b==0 on DIV/DIVU, set lo=0xFFFFFFFF, hi=a, and pulse div_by_zero with done; timing unchanged (33 cycles).
REQ-027 SHALL, for DIV a=0x80000000, b=0xFFFFFFFF, set lo=0x80000000, hi=0.
REQ-028 SHALL write hi from wdata on hi_we and lo on lo_we, only in IDLE; strobes in other states are ignored.
REQ-029 SHALL give start priority over hi_we/lo_we in the same IDLE cycle (writes dropped).
REQ-030 SHALL hold hi/lo unchanged outside REQ-020 and REQ-028.

Reset
REQ-031 SHALL on rst_n low immediately force IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, clearing iteration counter and partial results.
REQ-032 SHALL abort an in-flight operation on reset with no done pulse; first start after release behaves as a fresh request.

Configuration
REQ-033 SHALL compile the divider only when MULDIV_DIV_EN is defined.
REQ-034 SHALL, without MULDIV_DIV_EN, accept DIV/DIVU as IDLE->DONE (done one cycle after the start edge), leave hi/lo unchanged, keep div_by_zero=0.

Structure
REQ-035 SHALL place op encodings, the FSM state enum, and ITER_CNT=32 in shared package muldiv_pkg.
REQ-036 SHALL isolate sign conditioning (abs of inputs, final negation of results) in sub-module muldiv_sign, instantiated once.

Verification
REQ-037 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> after 33 cycles done=1, hi=0x00000001, lo=0xFFFFFFFE.
REQ-038 SHALL cover: MULT a=-6 (0xFFFFFFFA), b=11 -> hi=0xFFFFFFFF, lo=0xFFFFFFBE.
REQ-039 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=11, b=6 -> lo=1, hi=5.
REQ-040 SHALL cover: DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 with done.
REQ-041 SHALL cover: start and lo_we during busy -> ignored; lo_we=1, wdata=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle.
REQ-042 SHALL cover: rst_n low at cycle 10 of MULT -> outputs zero immediately, no done; new MULTU 3*4 after release -> lo=12 at cycle 33.
